// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone copy master: FSM state encoding,
// bus-beat constants and the wait-counter width.
// Latency: n/a (types and constants only). Backpressure: n/a.
package wb_pkg;

    // One-hot is not needed: six states fit comfortably in a 3-bit binary code.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RD_GAP = 3'd2,
        ST_WR     = 3'd3,
        ST_WR_GAP = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    // Byte-address step between consecutive 32-bit words.
    localparam int unsigned ADR_STRIDE = 4;

    // All four byte lanes are always enabled; the engine moves whole words.
    localparam logic [3:0] SEL_ALL = 4'hF;

    // Wait counter width; covers the full 1..255 timeout range.
    localparam int unsigned TMO_CNT_W = 8;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Per-transfer ack wait counter; flags the cycle in which the TIMEOUT-th ack-less stb cycle occurs.
// Latency: expired_o is combinational from the registered count and enable_i.
// Backpressure: none; clear_i has priority over enable_i.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_n_i    synchronous active-low reset
//   clear_i    hold the count at zero (driven while no strobe is outstanding)
//   enable_i   count this cycle (strobe high, no ack)
//   expired_o  this cycle is the TIMEOUT-th consecutive wait cycle
module wb_timeout_cnt
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // The counter holds the number of wait cycles already completed, so the
    // transfer expires during the cycle that would take it to TIMEOUT.
    localparam logic [TMO_CNT_W-1:0] CNT_LAST = TMO_CNT_W'(TIMEOUT - 1);

    logic [TMO_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = enable_i && !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone block-copy master: reads len words from src and writes them to dst, one word at a time.
// Latency: bus cycle starts the cycle after start_i; 4 cycles per word with a zero-wait slave, +1 FIN cycle.
// Backpressure: slave stalls by withholding ack; a transfer waiting TIMEOUT cycles aborts with err_o.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-low reset
//   start_i, abort_i           copy request (IDLE only) / cancel an active copy
//   src_adr_i, dst_adr_i       byte addresses, latched on an accepted start
//   len_i                      word count, latched on an accepted start
//   busy_o, done_o, err_o      status: active, completion pulse, sticky timeout
//   wbm_*                      Wishbone master bus
module wb_copy_master
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH+1:0] src_adr_i,
    input  logic [ADDR_WIDTH+1:0] dst_adr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [ADDR_WIDTH+1:0] wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i
);

    localparam int unsigned AW = ADDR_WIDTH + 2;
    localparam int unsigned LW = ADDR_WIDTH + 1;

    localparam logic [AW-1:0] STRIDE_A = AW'(ADR_STRIDE);
    localparam logic [LW-1:0] LEN_ONE  = LW'(1);

    state_e          state_q;
    logic            cyc_q;
    logic            stb_q;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [AW-1:0]   adr_q;
    logic [31:0]     dat_q;
    logic [31:0]     hold_q;
    logic [AW-1:0]   src_q;
    logic [AW-1:0]   dst_q;
    logic [LW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic [AW-1:0]   src_d;
    logic [AW-1:0]   dst_d;
    logic            tmo_expired;

    // Address arithmetic wraps naturally at the byte-address width.
    assign src_d = src_q + STRIDE_A;
    assign dst_d = dst_q + STRIDE_A;

    // The counter is held at zero whenever no strobe is out, so every RD/WR
    // entry starts a fresh wait window; an ack in a cycle stops it counting.
    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i     (wb_clk_i),
        .rst_n_i   (wb_rst_i),
        .clear_i   (!stb_q),
        .enable_i  (stb_q && !wbm_ack_i),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            hold_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Abort outranks everything, including an ack in the same cycle,
            // so an aborted transfer never advances addresses or count.
            if (state_q != ST_IDLE && abort_i) begin
                state_q <= ST_IDLE;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                we_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            src_q  <= src_adr_i;
                            dst_q  <= dst_adr_i;
                            cnt_q  <= len_i;
                            err_q  <= 1'b0;
                            busy_q <= 1'b1;
                            if (len_i == '0) begin
                                state_q <= ST_FIN;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_RD;
                                cyc_q   <= 1'b1;
                                stb_q   <= 1'b1;
                                we_q    <= 1'b0;
                                sel_q   <= SEL_ALL;
                                adr_q   <= src_adr_i;
                            end
                        end
                    end
                    ST_RD: begin
                        if (tmo_expired) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end else if (wbm_ack_i) begin
                            hold_q  <= wbm_dat_i;
                            stb_q   <= 1'b0;
                            state_q <= ST_RD_GAP;
                        end
                    end
                    ST_RD_GAP: begin
                        // dat_o only changes as the write strobe rises, so it
                        // stays stable across every stb-low cycle.
                        state_q <= ST_WR;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        adr_q   <= dst_q;
                        dat_q   <= hold_q;
                    end
                    ST_WR: begin
                        if (tmo_expired) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            we_q    <= 1'b0;
                            busy_q  <= 1'b0;
                        end else if (wbm_ack_i) begin
                            stb_q   <= 1'b0;
                            we_q    <= 1'b0;
                            state_q <= ST_WR_GAP;
                        end
                    end
                    ST_WR_GAP: begin
                        src_q <= src_d;
                        dst_q <= dst_d;
                        cnt_q <= cnt_q - LEN_ONE;
                        if (cnt_q == LEN_ONE) begin
                            state_q <= ST_FIN;
                            cyc_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RD;
                            stb_q   <= 1'b1;
                            adr_q   <= src_d;
                        end
                    end
                    ST_FIN: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule
